// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared types and constants for the pipeline-stage skid register.
//   - pipe_state_t : occupancy of the stage (empty, main only, main+skid)
//   - CTRL_RST / DATA_RST : per-bit reset value of the control / data bundles
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  // One bit each; replicated to bundle width where used.
  localparam logic CTRL_RST = 1'b0;
  localparam logic DATA_RST = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
//   One storage entry of the stage: a W-bit register with load enable and
//   synchronous active-low clear.
// Ports:
//   clk     in  1  clock, rising edge
//   reset   in  1  synchronous active-low clear to RST_VAL
//   load    in  1  capture d this cycle
//   d       in  W  next contents
//   q       out W  current contents
// ---------------------------------------------------------------------------
module pipe_slot #(
  parameter int             W       = 56,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  // d is only looked at when load is set, so junk on an unaccepted input
  // never reaches the register.
  always_comb begin
    val_d = val_q;
    if (load) val_d = d;
  end

  always_ff @(posedge clk) begin
    if (!reset) val_q <= RST_VAL;
    else        val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//   Pipeline-stage register with valid/ready handshake, flush and a 2-entry
//   skid buffer. in_ready comes straight from a flop, so a downstream stall
//   never creates a combinational path back upstream. Control outputs are
//   masked to zero on bubbles so enables never fire for an invalid slot.
//
// Optional feature macro: PIPE_STALL_CNT_EN
//   defined     -> CNT_W parameter and stall_cnt port present; saturating
//                  count of cycles with out_valid=1 and out_ready=0,
//                  cleared by reset only.
//   not defined -> no counter, no stall_cnt port.
//
// Ports:
//   clk        in   1       clock, rising edge
//   reset      in   1       synchronous, active-low
//   flush      in   1       drop all held entries and the same-cycle input
//   in_valid   in   1       upstream entry valid
//   in_ready   out  1       stage accepts entry (registered)
//   in_ctrl    in   CTRL_W  upstream control bundle
//   in_data    in   DATA_W  upstream data bundle
//   out_valid  out  1       head entry valid
//   out_ready  in   1       downstream consumes head
//   out_ctrl   out  CTRL_W  head control, zero when out_valid=0
//   out_data   out  DATA_W  head data, holds last value when out_valid=0
//   stall_cnt  out  CNT_W   stall cycle count (PIPE_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 40,
  parameter int CTRL_W = 16
`ifdef PIPE_STALL_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam int                SLOT_W   = CTRL_W + DATA_W;
  localparam logic [SLOT_W-1:0] SLOT_RST = {{CTRL_W{CTRL_RST}}, {DATA_W{DATA_RST}}};

  pipe_state_t       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              main_load, skid_load;
  logic [SLOT_W-1:0] main_d, main_q, skid_q;
  logic              head_vld;
  logic              in_xfer, out_xfer;

  assign head_vld = (state_q != ST_EMPTY);
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = head_vld & out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = {in_ctrl, in_data};
    if (flush) begin
      // Data registers keep their contents; only occupancy is dropped.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            state_d   = ST_SKID;
            skid_load = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the skid entry moves forward.
          if (out_xfer) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Ready for next cycle is decided now and held in a flop.
    in_ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(.W(SLOT_W), .RST_VAL(SLOT_RST)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.W(SLOT_W), .RST_VAL(SLOT_RST)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     ({in_ctrl, in_data}),
    .q     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = head_vld;
  assign out_ctrl  = main_q[SLOT_W-1:DATA_W] & {CTRL_W{head_vld}};
  assign out_data  = main_q[DATA_W-1:0];

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating; flush has no effect on the count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (head_vld && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//   Bench for pipe_stage_skid_reg. The reference is a 2-deep FIFO queue with
//   a "ready = fewer than two held" rule, a held-data register and a
//   saturating stall count; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 40;
  localparam int CTRL_W = 16;
`ifdef PIPE_STALL_CNT_EN
  localparam int CNT_W  = 4;
`else
  localparam int CNT_W  = 16;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

`ifdef PIPE_STALL_CNT_EN
  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );
`else
  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
  );
`endif

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  logic [DATA_W-1:0] m_data = '0;
  int                m_stall = 0;

  always @(posedge clk) begin
    bit   rdy, vld;
    ent_t e;
    rdy = (mq.size() < 2);
    vld = (mq.size() > 0);
    if (!reset) begin
      mq.delete();
      m_data  = '0;
      m_stall = 0;
    end else begin
      if (vld && !out_ready && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        if (vld && out_ready) void'(mq.pop_front());
        if (in_valid && rdy) begin
          e.c = in_ctrl;
          e.d = in_data;
          mq.push_back(e);
        end
      end
      if (mq.size() > 0) m_data = mq[0].d;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
      chk("m_in_ready",  {63'd0, in_ready},  {63'd0, mq.size() < 2});
      chk("m_out_ctrl",  64'(out_ctrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'd0);
      chk("m_out_data",  64'(out_data), 64'(m_data));
`ifdef PIPE_STALL_CNT_EN
      chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end
  end

  // Apply one cycle of inputs; returns just after the following falling edge.
  task automatic step(input logic rst_n, input logic fl, input logic iv, input logic ordy,
                      input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    reset     = rst_n;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_ctrl   = c;
    in_data   = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held two cycles with in_valid high
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 40'h12_3456_789A);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 40'h12_3456_789A);
    chk_en = 1'b1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl), 64'd0);
    chk("rst_out_data",  64'(out_data), 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
`ifdef PIPE_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // 2: streaming, one-cycle latency, no gaps
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, CTRL_W'(i), DATA_W'(i * 257));
      chk("stream_ctrl",  64'(out_ctrl), 64'(i));
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hDEAD, 40'hBAD);
    chk("stream_drain_valid", {63'd0, out_valid}, 64'd0);
    chk("stream_drain_ctrl",  64'(out_ctrl), 64'd0);
    chk("stream_drain_data",  64'(out_data), 64'd4112);

    // 3: skid A,B then C stalled upstream
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h000A, 40'hA0);
    chk("skid_a_ctrl", 64'(out_ctrl), 64'h000A);
    chk("skid_a_rdy",  {63'd0, in_ready}, 64'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h000B, 40'hB0);
    chk("skid_b_ctrl", 64'(out_ctrl), 64'h000A);
    chk("skid_b_rdy",  {63'd0, in_ready}, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h000C, 40'hC0);
    chk("skid_c_ctrl", 64'(out_ctrl), 64'h000A);
    chk("skid_c_rdy",  {63'd0, in_ready}, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h000C, 40'hC0);
    chk("skid_rel_b",   64'(out_ctrl), 64'h000B);
    chk("skid_rel_rdy", {63'd0, in_ready}, 64'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h000C, 40'hC0);
    chk("skid_rel_c",    64'(out_ctrl), 64'h000C);
    chk("skid_rel_cdat", 64'(out_data), 64'hC0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 40'h0);
    chk("skid_empty", {63'd0, out_valid}, 64'd0);

    // 4: flush while in SKID with a same-cycle input
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h000D, 40'hD0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h000E, 40'hE0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h000F, 40'hF0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ctrl",  64'(out_ctrl), 64'd0);
    chk("flush_rdy",   {63'd0, in_ready}, 64'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 40'h0);
    chk("flush_drop",  {63'd0, out_valid}, 64'd0);
    chk("flush_hold_data", 64'(out_data), 64'hD0);

    // 5: stall counter saturation, flush keeps the count
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 40'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0077, 40'h77);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 40'h0);
    chk("stall_hold_ctrl", 64'(out_ctrl), 64'h0077);
`ifdef PIPE_STALL_CNT_EN
    chk("stall_sat", 64'(stall_cnt), 64'd15);
`endif
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 40'h0);
    chk("stall_flush_valid", {63'd0, out_valid}, 64'd0);
`ifdef PIPE_STALL_CNT_EN
    chk("stall_after_flush", 64'(stall_cnt), 64'd15);
`endif

    // 6: random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      logic rn, fl, iv, orr;
      rn  = ($urandom_range(499) != 0);
      fl  = ($urandom_range(19) == 0);
      iv  = ($urandom_range(1) == 1);
      orr = ($urandom_range(9) < 6);
      step(rn, fl, iv, orr, CTRL_W'($urandom), {8'($urandom), 32'($urandom)});
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
